// File: rtl/restador_serie_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package restador_serie_pkg;

  localparam int ANCHO = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restador_serie_completo.sv
// Combinational full-subtractor cell: d = a - b - bi, with borrow-out bo.
module restador_completo (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/restador_serie.sv
// Bit-serial N-bit subtractor (A - B - Bin), LSB first, with an inicio/listo handshake.
module restador_serie
  import restador_serie_pkg::*;
#(
  parameter int N = ANCHO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] Resta,
  output logic         Bout
);

  localparam int CW = $clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   resta_q, resta_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           cell_d, cell_bo;

  restador_completo u_celda (
    .a  (ra_q[0]),
    .b  (rb_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    resta_d = resta_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (inicio) begin
          ra_d    = A;
          rb_d    = B;
          br_d    = Bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d = {cell_d, res_q[N-1:1]};
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        br_d  = cell_bo;
        // The last shift publishes the finished word; cnt holds so it never wraps.
        if (cnt_q == CW'(N - 1)) begin
          resta_d = {cell_d, res_q[N-1:1]};
          bout_d  = cell_bo;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      resta_q <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      resta_q <= resta_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign ocupado = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign listo   = (state_q == ST_DONE);
  assign Resta   = resta_q;
  assign Bout    = bout_q;

endmodule

// File: tb/tb_restador_serie.sv
// Self-checking bench for restador_serie (N=4): vector table, randomized model checks, corner sequences.
module tb_restador_serie;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inicio;
  logic [N-1:0] A, B;
  logic         Bin;
  logic         ocupado, listo, Bout;
  logic [N-1:0] Resta;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] exp_resta;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[6];

  restador_serie #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .Bin     (Bin),
    .ocupado (ocupado),
    .listo   (listo),
    .Resta   (Resta),
    .Bout    (Bout)
  );

  always #5 clk = ~clk;

  // Reference 4-bit adder: returns {carry_out, sum}.
  function automatic logic [N:0] sumador_4bits(input logic [N-1:0] x, input logic [N-1:0] y, input logic cin);
    return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // One full operation: sample, then watch ocupado/listo until the block returns idle.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                               output logic [N-1:0] got_resta, output logic got_bout,
                               output int busy, output int listo_cnt, output int listo_pos);
    bit done = 0;
    busy = 0; listo_cnt = 0; listo_pos = -1;
    got_resta = '0; got_bout = 1'b0;
    @(negedge clk);
    A = a; B = b; Bin = bin; inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ocupado) busy++;
      if (listo) begin
        listo_cnt++;
        listo_pos = busy;
        got_resta = Resta;
        got_bout  = Bout;
      end
      if (!ocupado && busy > 0) done = 1;
    end
    if (!done) checkOutput("op_timeout", 0, 1);
  endtask

  task automatic check_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input logic [N-1:0] exp_r, input logic exp_b, input bit timing);
    logic [N-1:0] r;
    logic         bo;
    logic [N:0]   s;
    int busy, lc, lp;
    applyStimulus(a, b, bin, r, bo, busy, lc, lp);
    s = sumador_4bits(r, b, bin);
    checkOutput({tag, "_resta"}, int'(r), int'(exp_r));
    checkOutput({tag, "_bout"}, int'(bo), int'(exp_b));
    checkOutput({tag, "_adder_sum"}, int'(s[N-1:0]), int'(a));
    checkOutput({tag, "_adder_cout"}, int'(s[N]), int'(bo));
    if (timing) begin
      checkOutput({tag, "_busy_cycles"}, busy, N + 1);
      checkOutput({tag, "_listo_count"}, lc, 1);
      checkOutput({tag, "_listo_last_busy"}, lp, N + 1);
    end
  endtask

  initial begin
    int diff;
    int pulses[$];
    int lc;
    int waited;
    logic [N-1:0] ra, rb;
    logic rbin;

    vecs[0] = '{4'd2,  4'd1,  1'b0, 4'd1,  1'b0};
    vecs[1] = '{4'd4,  4'd10, 1'b0, 4'd10, 1'b1};
    vecs[2] = '{4'd10, 4'd10, 1'b0, 4'd0,  1'b0};
    vecs[3] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[4] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[5] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0};

    rst_n = 1'b0; inicio = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ocupado", int'(ocupado), 0);
    checkOutput("reset_listo", int'(listo), 0);
    checkOutput("reset_resta", int'(Resta), 0);
    checkOutput("reset_bout", int'(Bout), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
               vecs[i].exp_resta, vecs[i].exp_bout, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = N'($urandom); rb = N'($urandom); rbin = 1'($urandom);
      diff = int'(ra) - int'(rb) - int'(rbin);
      check_op($sformatf("rnd%0d", i), ra, rb, rbin, N'(diff + (1 << N)), diff < 0, 1'b0);
    end

    // inicio and operand changes during CALC must be ignored.
    @(negedge clk);
    A = 4'd12; B = 4'd5; Bin = 1'b0; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 4'd1; B = 4'd1; Bin = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lc = 0;
    for (int i = 0; i < 12; i++) begin
      if (listo) begin
        lc++;
        checkOutput("ignore_resta", int'(Resta), 7);
        checkOutput("ignore_bout", int'(Bout), 0);
      end
      @(negedge clk);
    end
    checkOutput("ignore_listo_count", lc, 1);
    checkOutput("ignore_idle_after", int'(ocupado), 0);

    // Asynchronous reset in the second CALC cycle discards the operation.
    @(negedge clk);
    A = 4'd9; B = 4'd2; Bin = 1'b0; inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ocupado", int'(ocupado), 0);
    checkOutput("rst_async_resta", int'(Resta), 0);
    checkOutput("rst_async_bout", int'(Bout), 0);
    checkOutput("rst_async_listo", int'(listo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (listo || ocupado) lc++;
    end
    checkOutput("rst_no_listo", lc, 0);
    check_op("after_rst", 4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1);

    // inicio held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    A = 4'd7; B = 4'd3; Bin = 1'b0; inicio = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (listo) begin
        pulses.push_back(c);
        checkOutput("hold_resta", int'(Resta), 4);
        checkOutput("hold_bout", int'(Bout), 0);
      end
    end
    inicio = 1'b0;
    checkOutput("hold_pulse_count", pulses.size() >= 4, 1);
    for (int k = 1; k < pulses.size(); k++)
      checkOutput("hold_spacing", pulses[k] - pulses[k-1], N + 2);
    waited = 0;
    while (ocupado && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("hold_return_idle", int'(ocupado), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
